// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, byte framing and
// mode-0 clock polarity/phase.
package spi_pkg;

  localparam int   SPI_BYTE_BITS = 8;
  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;

  typedef enum logic [2:0] {
    IDLE_WAIT,
    IDLE,
    SETUP,
    XFER,
    GAP,
    HOLD
  } spi_state_e;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period counter producing one-cycle rise/fall strobes while enabled.
// The count restarts whenever enable is low, preset to the requested phase.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic startHigh_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          wrap;

  assign wrap   = en_i && (cnt_q == HALF_LAST);
  assign rise_o = wrap && !phase_q;
  assign fall_o = wrap && phase_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q   <= '0;
      phase_q <= startHigh_i;
    end else if (wrap) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI master with a valid/ready byte interface; bytes
// handed over before send_last share a single slave-select assertion.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 4,
  parameter int BYTE_GAP = 4,
  parameter int SS_IDLE  = 8
) (
  input  logic                     ext_clk,
  input  logic                     rst,
  input  logic [SPI_BYTE_BITS-1:0] send_data,
  input  logic                     send_valid,
  input  logic                     send_last,
  output logic                     send_ready,
  output logic [SPI_BYTE_BITS-1:0] recv_data,
  output logic                     recv_valid,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic                     ss
);

  localparam int CNT_MAX = maxOf(maxOf(CLK_DIV, SS_SETUP), maxOf(BYTE_GAP, SS_IDLE));
  localparam int CW      = $clog2(CNT_MAX);
  localparam int BW      = $clog2(SPI_BYTE_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(SPI_BYTE_BITS - 1);

  spi_state_e               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, cntLimit;
  logic [BW-1:0]            bit_q, bit_d;
  logic [SPI_BYTE_BITS-1:0] tx_q, tx_d, rx_q, rx_d, recvData_q, recvData_d;
  logic                     last_q, last_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                     ss_q, ss_d, ready_q, ready_d, recvValid_q, recvValid_d;
  logic                     rise, fall, handshake, cntHit, byteDone;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i      (ext_clk),
    .rst_i      (rst),
    .en_i       (state_q == XFER),
    .startHigh_i(state_q == SETUP),
    .rise_o     (rise),
    .fall_o     (fall)
  );

  assign handshake = send_valid && ready_q;
  assign byteDone  = (state_q == XFER) && fall && (bit_q == LAST_BIT);
  assign cntLimit  = (state_q == IDLE_WAIT) ? CW'(SS_IDLE - 1)  :
                     (state_q == SETUP)     ? CW'(SS_SETUP - 1) :
                     (state_q == GAP)       ? CW'(BYTE_GAP - 1) :
                     (state_q == HOLD)      ? CW'(CLK_DIV - 1)  : '0;
  assign cntHit    = (cnt_q == cntLimit);

  always_ff @(posedge ext_clk) begin
    if (rst) begin
      state_q     <= IDLE_WAIT;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      last_q      <= 1'b0;
      sclk_q      <= SPI_CPOL;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      ready_q     <= 1'b0;
      recvValid_q <= 1'b0;
      recvData_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      last_q      <= last_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      ready_q     <= ready_d;
      recvValid_q <= recvValid_d;
      recvData_q  <= recvData_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE_WAIT: if (cntHit)    state_d = IDLE;
      IDLE:      if (handshake) state_d = SETUP;
      SETUP:     if (cntHit)    state_d = XFER;
      XFER:      if (byteDone)  state_d = last_q ? HOLD : GAP;
      GAP:       if (handshake) state_d = XFER;
      HOLD:      if (cntHit)    state_d = IDLE_WAIT;
      default:                  state_d = IDLE_WAIT;
    endcase
  end

  // Outputs are computed from the next state so every pin leaves a flop.
  // The SETUP phase doubles as the low half before the first rise.
  always_comb begin
    cnt_d       = (state_d != state_q) ? '0 : (cntHit ? cnt_q : cnt_q + 1'b1);
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    last_d      = last_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    recvData_d  = recvData_q;
    recvValid_d = 1'b0;
    if (handshake) begin
      tx_d   = send_data;
      last_d = send_last;
      mosi_d = send_data[SPI_BYTE_BITS-1];
      bit_d  = '0;
    end
    if ((state_q == SETUP) && (state_d == XFER)) begin
      sclk_d = ~SPI_CPOL;
    end else if (rise) begin
      sclk_d = ~SPI_CPOL;
    end else if (fall) begin
      sclk_d = SPI_CPOL;
    end
    if ((sclk_d != SPI_CPOL) && (sclk_q == SPI_CPOL)) begin
      rx_d = {rx_q[SPI_BYTE_BITS-2:0], miso};
    end
    if (fall) begin
      tx_d   = tx_q << 1;
      mosi_d = tx_q[SPI_BYTE_BITS-2];
      bit_d  = bit_q + 1'b1;
    end
    if (byteDone) begin
      recvData_d  = rx_q;
      recvValid_d = 1'b1;
    end
    ss_d    = (state_d == IDLE_WAIT) || (state_d == IDLE);
    ready_d = (state_d == IDLE) || ((state_d == GAP) && (state_q == GAP) && cntHit);
  end

  assign send_ready = ready_q;
  assign recv_data  = recvData_q;
  assign recv_valid = recvValid_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign ss         = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: directed and random byte streams against a cycle-timing
// model and a byte-level slave, with loopback or a canned slave reply.
module tb_spi_master;

  localparam int CD = 4;
  localparam int SU = 4;
  localparam int BG = 3;
  localparam int SI = 9;

  logic       ext_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] send_data = 8'h00;
  logic       send_valid = 1'b0;
  logic       send_last = 1'b0;
  logic       send_ready, recv_valid, sclk, mosi, miso, ss;
  logic [7:0] recv_data;

  bit         loopback = 1'b1;
  logic [7:0] curReply = 8'h00;
  logic [2:0] slaveBit = 3'd0;
  logic       slavePrevSclk = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         lastSsRise = 0;
  logic [7:0] expQ[$];

  spi_master #(.CLK_DIV(CD), .SS_SETUP(SU), .BYTE_GAP(BG), .SS_IDLE(SI)) dut (
    .ext_clk   (ext_clk),
    .rst       (rst),
    .send_data (send_data),
    .send_valid(send_valid),
    .send_last (send_last),
    .send_ready(send_ready),
    .recv_data (recv_data),
    .recv_valid(recv_valid),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .ss        (ss)
  );

  always #5 ext_clk = ~ext_clk;

  always @(posedge ext_clk) cyc <= cyc + 1;

  // Slave model: presents its reply MSB first and moves on after each sclk fall.
  assign miso = loopback ? mosi : curReply[3'd7 - slaveBit];

  always @(negedge ext_clk) begin
    if (ss === 1'b1) slaveBit <= 3'd0;
    else if (slavePrevSclk && !sclk) slaveBit <= slaveBit + 3'd1;
    slavePrevSclk <= sclk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Follows one byte from its handshake cycle A through to the next ready.
  task automatic checkByte(input int A, input logic [7:0] d, input bit last, input bit fromIdle);
    int r0, f, riseCnt, recvCyc, rdy, ssR, misplaced;
    int riseCyc[8];
    logic [7:0] mosiByte, got, want;
    bit ssBroke, seen, sclkBad, extraRv;
    logic prev;
    r0 = fromIdle ? A + 1 + SU : A + 1 + CD;
    f = r0 + 15 * CD;
    want = expQ.pop_front();
    foreach (riseCyc[k]) riseCyc[k] = -1;
    @(negedge ext_clk);
    send_valid = 1'b0;
    send_data = 8'($urandom);
    checkOutput("ssLowAfterHs", ss, 0);
    checkOutput("mosiBit7", mosi, d[7]);
    checkOutput("readyDrop", send_ready, 0);
    if (fromIdle) checkOutput("ssIdleGap", (cyc - lastSsRise) >= SI, 1);
    prev = sclk; riseCnt = 0; seen = 0; ssBroke = 0; mosiByte = 0; got = 0; recvCyc = -1;
    for (int i = 0; i < SU + 16 * CD + 8 && !seen; i++) begin
      @(negedge ext_clk);
      if (sclk && !prev) begin
        if (riseCnt < 8) riseCyc[riseCnt] = cyc;
        mosiByte = {mosiByte[6:0], mosi};
        riseCnt++;
      end
      prev = sclk;
      if (ss) ssBroke = 1;
      if (recv_valid) begin
        seen = 1; recvCyc = cyc; got = recv_data;
      end
    end
    misplaced = 0;
    for (int k = 0; k < 8; k++) if (riseCyc[k] != r0 + 2 * k * CD) misplaced++;
    checkOutput("recvSeen", seen, 1);
    checkOutput("riseCount", riseCnt, 8);
    checkOutput("firstRise", riseCyc[0], r0);
    checkOutput("risePlacement", misplaced, 0);
    checkOutput("mosiStream", mosiByte, d);
    checkOutput("recvCycle", recvCyc, f);
    checkOutput("recvData", got, want);
    checkOutput("ssHeldLow", ssBroke, 0);
    @(negedge ext_clk);
    checkOutput("recvPulse", recv_valid, 0);
    rdy = -1; ssR = -1; sclkBad = 0; extraRv = 0;
    for (int i = 0; i < CD + SI + BG + 20; i++) begin
      if (sclk) sclkBad = 1;
      if (recv_valid) extraRv = 1;
      if (ss && ssR < 0) ssR = cyc;
      if (send_ready) begin
        rdy = cyc;
        break;
      end
      @(negedge ext_clk);
    end
    if (last) begin
      checkOutput("ssRise", ssR, f + CD);
      checkOutput("readyAfterIdle", rdy, f + CD + SI);
      lastSsRise = ssR;
    end else begin
      checkOutput("readyInGap", rdy, f + BG);
      checkOutput("ssGapLow", ssR, -1);
    end
    checkOutput("tailQuiet", {sclkBad, extraRv}, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit last, input bit fromIdle,
                               input logic [7:0] reply, input int delay);
    int viol, A;
    bit seen;
    curReply = reply;
    expQ.push_back(loopback ? d : reply);
    viol = 0;
    for (int i = 0; i < delay; i++) begin
      if (ss !== fromIdle || sclk !== 1'b0 || send_ready !== 1'b1) viol++;
      @(negedge ext_clk);
    end
    if (delay > 0) checkOutput("waitHold", viol, 0);
    send_data = d; send_last = last; send_valid = 1'b1;
    seen = 0; A = 0;
    for (int i = 0; i < 50; i++) begin
      if (send_ready) begin
        seen = 1; A = cyc;
        break;
      end
      @(negedge ext_clk);
    end
    checkOutput("handshake", seen, 1);
    if (seen) checkByte(A, d, last, fromIdle);
    else begin
      send_valid = 1'b0;
      void'(expQ.pop_front());
    end
  endtask

  // Waits for ready after a reset release at cycle rel, hammering send_valid
  // with changing data; hands over d on the first ready cycle.
  task automatic resetRecover(input int rel, input logic [7:0] d);
    int rdy, rv, ssBad;
    rdy = -1; rv = 0; ssBad = 0;
    for (int i = 0; i < SI + 20; i++) begin
      if (recv_valid) rv++;
      if (!ss || sclk) ssBad++;
      if (send_ready) begin
        rdy = cyc;
        break;
      end
      send_valid = 1'b1; send_last = 1'b1; send_data = 8'($urandom);
      @(negedge ext_clk);
    end
    checkOutput("rstReady", rdy, rel + SI);
    checkOutput("rstNoRecv", rv, 0);
    checkOutput("rstSsHigh", ssBad, 0);
    lastSsRise = rel;
    if (rdy >= 0) begin
      loopback = 1'b1;
      send_data = d; send_valid = 1'b1; send_last = 1'b1;
      expQ.push_back(d);
      checkByte(rdy, d, 1'b1, 1'b1);
    end
  endtask

  initial begin
    int rel, rises, n;
    bit reached;
    logic prev;
    logic [7:0] bytes3[3];
    bytes3[0] = 8'h01; bytes3[1] = 8'h80; bytes3[2] = 8'hFF;

    repeat (3) @(negedge ext_clk);
    checkOutput("rstSclk0", sclk, 0);
    checkOutput("rstSs1", ss, 1);
    checkOutput("rstMosi0", mosi, 0);
    checkOutput("rstReady0", send_ready, 0);
    checkOutput("rstRecvValid0", recv_valid, 0);
    checkOutput("rstRecvData0", recv_data, 0);
    rst = 1'b0;
    rel = cyc;
    resetRecover(rel, 8'h96);

    $display("[TB] loopback 0xA5");
    loopback = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b1, 8'h00, 0);

    $display("[TB] slave reply 0x3C to 0xC3");
    loopback = 1'b0;
    applyStimulus(8'hC3, 1'b1, 1'b1, 8'h3C, 2);

    $display("[TB] three bytes in one frame");
    loopback = 1'b1;
    for (int b = 0; b < 3; b++) applyStimulus(bytes3[b], b == 2, b == 0, 8'h00, 0);

    $display("[TB] long wait in gap");
    loopback = 1'b0;
    applyStimulus(8'h5E, 1'b0, 1'b1, 8'h81, 1);
    applyStimulus(8'h27, 1'b1, 1'b0, 8'hE4, 50);

    $display("[TB] reset during bit 4");
    loopback = 1'b1;
    send_data = 8'h5A; send_last = 1'b1; send_valid = 1'b1;
    reached = 0;
    for (int i = 0; i < 50 && !send_ready; i++) @(negedge ext_clk);
    @(negedge ext_clk);
    send_valid = 1'b0;
    prev = sclk; rises = 0;
    for (int i = 0; i < SU + 16 * CD; i++) begin
      @(negedge ext_clk);
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 5) begin
        reached = 1;
        break;
      end
    end
    checkOutput("rstReachedBit4", reached, 1);
    rst = 1'b1;
    @(negedge ext_clk);
    rst = 1'b0;
    rel = cyc;
    checkOutput("rstMidSs", ss, 1);
    checkOutput("rstMidSclk", sclk, 0);
    resetRecover(rel, 8'h3D);

    $display("[TB] random frames");
    for (int t = 0; t < 8; t++) begin
      loopback = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      for (int b = 0; b < n; b++)
        applyStimulus(8'($urandom), b == n - 1, b == 0, 8'($urandom), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
